// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a 1-cycle sync RAM, feeds IFID through a small fetch queue.
// Optional IF_PERF_CNT_EN adds perf_fetch_o / perf_bubble_o counters.
module if_fetch_stage #(
  parameter int          DATA_WIDTH = 64,
  parameter int          INST_WIDTH = 32,
  parameter int          RAM_SIZE   = 16,
  parameter int          FQ_DEPTH   = 2,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall_i,
  input  logic                             redirect_i,
  input  logic [DATA_WIDTH-1:0]            redirect_pc_i,
  output logic                             imem_req_o,
  output logic [RAM_SIZE-1:0]              imem_addr_o,
  input  logic [INST_WIDTH-1:0]            imem_rdata_i,
  output logic [DATA_WIDTH+INST_WIDTH:0]   ifid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [63:0]                      perf_fetch_o,
  output logic [63:0]                      perf_bubble_o
`endif
);

  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int PW = $clog2(FQ_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
    logic                  enable;
  } IFID_Pipe_t;

  logic [DATA_WIDTH-1:0] pc_q, req_pc_q;
  logic                  inflight_q;
  logic [CW-1:0]         count_q;
  logic [PW-1:0]         head_q, tail_q;
  logic [DATA_WIDTH-1:0] fq_pc   [FQ_DEPTH];
  logic [INST_WIDTH-1:0] fq_inst [FQ_DEPTH];
  IFID_Pipe_t            ifid_q;

  logic [CW:0] occupancy;
  logic        issue, rsp_vld, q_empty, push, pop, load_vld, load_bubble;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Issue ignores a same-cycle pop, so the queue can never overflow.
  assign occupancy   = (CW+1)'(count_q) + (CW+1)'(inflight_q);
  assign issue       = !rst && !redirect_i && (occupancy < (CW+1)'(FQ_DEPTH));
  assign rsp_vld     = inflight_q && !redirect_i && !rst;
  assign q_empty     = (count_q == '0);
  assign pop         = !rst && !redirect_i && !stall_i && !q_empty;
  assign push        = rsp_vld && (stall_i || !q_empty);
  assign load_vld    = !rst && !redirect_i && !stall_i && (!q_empty || rsp_vld);
  assign load_bubble = !rst && !redirect_i && !stall_i && q_empty && !rsp_vld;

  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q[RAM_SIZE+1:2];
  assign ifid_o      = ifid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC[DATA_WIDTH-1:0];
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else if (redirect_i) begin
      pc_q       <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_q + DATA_WIDTH'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_i) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      if (push) tail_q <= ptr_next(tail_q);
      if (pop)  head_q <= ptr_next(head_q);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fq_pc[tail_q]   <= req_pc_q;
      fq_inst[tail_q] <= imem_rdata_i;
    end
  end

  // Redirect beats stall: the stage drops to a bubble even while ID is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_q <= '0;
    end else if (redirect_i) begin
      ifid_q.enable <= 1'b0;
    end else if (!stall_i) begin
      if (!q_empty) begin
        ifid_q <= '{pc: fq_pc[head_q], inst: fq_inst[head_q], enable: 1'b1};
      end else if (rsp_vld) begin
        ifid_q <= '{pc: req_pc_q, inst: imem_rdata_i, enable: 1'b1};
      end else begin
        ifid_q.enable <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_o  <= '0;
      perf_bubble_o <= '0;
    end else begin
      if (load_vld)    perf_fetch_o  <= perf_fetch_o + 64'd1;
      if (load_bubble) perf_bubble_o <= perf_bubble_o + 64'd1;
    end
  end
`else
  logic unused_load;
  assign unused_load = load_vld ^ load_bubble;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: scoreboard of expected program-order PCs plus directed timing checks.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall_i, redirect_i;
  logic [63:0] redirect_pc_i;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [96:0] ifid_o;
`ifdef IF_PERF_CNT_EN
  logic [63:0] perf_fetch_o, perf_bubble_o;
`endif

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .ifid_o(ifid_o)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_o(perf_fetch_o), .perf_bubble_o(perf_bubble_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  // Synchronous instruction RAM: data valid the cycle after the request.
  always @(posedge clk) if (imem_req_o) imem_rdata_i <= inst_of(imem_addr_o);

  wire [63:0] o_pc   = ifid_o[96:33];
  wire [31:0] o_inst = ifid_o[32:1];
  wire        o_en   = ifid_o[0];

  int              n_checks = 0;
  int              n_fail   = 0;
  longint unsigned sb_q[$];
  longint unsigned exp_fetch  = 0;
  longint unsigned exp_bubble = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_stream(input logic [63:0] start, input int n);
    sb_q.delete();
    for (int i = 0; i < n; i++) sb_q.push_back(start + 64'(4 * i));
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    bit loaded, was_rst;
    logic [63:0] e;
    loaded  = !rst && !redirect_i && !stall_i;
    was_rst = rst;
    @(posedge clk);
    #1;
    if (was_rst) begin
      exp_fetch  = 0;
      exp_bubble = 0;
    end else if (loaded) begin
      if (o_en) exp_fetch++;
      else      exp_bubble++;
    end
    if (loaded && o_en) begin
      if (sb_q.size() == 0) begin
        check("sb_extra", 64'(o_en), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_pc", o_pc, e);
        check("sb_inst", 64'(o_inst), 64'(inst_of(e[17:2])));
      end
    end
  endtask

  task automatic wait_valid(input string tag, input logic [63:0] exp_pc);
    bit seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (o_en) seen = 1;
      else tick();
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_pc"}, o_pc, exp_pc);
  endtask

  initial begin
    logic [63:0] exp_pcs [3];
    exp_pcs[0] = 64'd12; exp_pcs[1] = 64'd16; exp_pcs[2] = 64'd20;
    rst = 1; stall_i = 0; redirect_i = 0; redirect_pc_i = '0;
    repeat (3) tick();
    check("rst_req", 64'(imem_req_o), 64'd0);
    check("rst_ifid_zero", 64'(ifid_o != '0), 64'd0);

    // Reset release and first-fetch latency
    expect_stream(64'h0, 400);
    rst = 0;
    #1;
    check("addr0", 64'(imem_addr_o), 64'd0);
    check("req0", 64'(imem_req_o), 64'd1);
    tick();
    check("addr1", 64'(imem_addr_o), 64'd1);
    check("lat_bubble", 64'(o_en), 64'd0);
    tick();
    check("addr2", 64'(imem_addr_o), 64'd2);
    check("lat_en", 64'(o_en), 64'd1);
    check("lat_pc0", o_pc, 64'd0);
    tick();
    check("pc4", o_pc, 64'd4);
    tick();
    check("pc8", o_pc, 64'd8);

    // Stall for 4 cycles
    stall_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_req", 64'(imem_req_o), (i == 0) ? 64'd1 : 64'd0);
      tick();
      check("stall_hold_pc", o_pc, 64'd8);
      check("stall_hold_en", 64'(o_en), 64'd1);
    end
    stall_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("release_en", 64'(o_en), 64'd1);
      check("release_pc", o_pc, exp_pcs[i]);
    end
    repeat (5) tick();

    // Redirect while streaming
    redirect_i = 1; redirect_pc_i = 64'h100;
    tick();
    redirect_i = 0;
    expect_stream(64'h100, 400);
    check("redir_t1_en", 64'(o_en), 64'd0);
    tick();
    check("redir_t2_en", 64'(o_en), 64'd0);
    tick();
    check("redir_t3_en", 64'(o_en), 64'd1);
    check("redir_t3_pc", o_pc, 64'h100);
    repeat (6) tick();

    // Redirect together with stall on a full queue
    stall_i = 1;
    repeat (3) tick();
    redirect_i = 1; redirect_pc_i = 64'h200;
    tick();
    redirect_i = 0; stall_i = 0;
    expect_stream(64'h200, 400);
    check("rs_en", 64'(o_en), 64'd0);
    wait_valid("rs_first", 64'h200);
    repeat (4) tick();

    // Reset with queued entries
    stall_i = 1;
    repeat (3) tick();
    rst = 1;
    #1;
    check("mrst_req", 64'(imem_req_o), 64'd0);
    tick();
    check("mrst_ifid_zero", 64'(ifid_o != '0), 64'd0);
    rst = 0; stall_i = 0;
    expect_stream(64'h0, 400);
    wait_valid("mrst_first", 64'h0);
    repeat (10) tick();

    // A bubble-producing redirect before the counters are read
    redirect_i = 1; redirect_pc_i = 64'h300;
    tick();
    redirect_i = 0;
    expect_stream(64'h300, 400);
    repeat (6) tick();
`ifdef IF_PERF_CNT_EN
    check("perf_fetch", perf_fetch_o, 64'(exp_fetch));
    check("perf_bubble", perf_bubble_o, 64'(exp_bubble));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
